// File: rtl/fp32_divider.sv
// Sequential IEEE-754 single-precision divider.
// Restoring significand divider (one quotient bit per cycle), then round-to-nearest-even.
module fp32_divider #(
  parameter logic [31:0] NAN_VALUE = 32'h7FC0_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_dividend,
  input  logic [31:0] i_divisor,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_quot,
  output logic [3:0]  o_flags
);
  // state | meaning
  // IDLE  | waiting for an operand pair; o_ready=1
  // DIV   | one quotient bit per cycle, counter 0..25
  // RND   | normalise, round, range check
  // OUT   | result presented, held until i_ready
  typedef enum logic [1:0] {IDLE, DIV, RND, OUT} state_t;

  state_t             state;
  logic        [23:0] div_b;
  logic        [24:0] rem;
  logic        [25:0] quo;
  logic        [4:0]  cnt;
  logic signed [9:0]  exp_q;
  logic               sign_q;

  logic [7:0]  ea, eb;
  logic [22:0] fa, fb;
  logic        nan_a, nan_b, inf_a, inf_b, zero_a, zero_b, sign_in;
  logic        spec_hit;
  logic [31:0] spec_quot;
  logic [3:0]  spec_flags;

  assign ea      = i_dividend[30:23];
  assign eb      = i_divisor[30:23];
  assign fa      = i_dividend[22:0];
  assign fb      = i_divisor[22:0];
  assign sign_in = i_dividend[31] ^ i_divisor[31];
  assign nan_a   = (ea == 8'hFF) && (fa != 23'd0);
  assign nan_b   = (eb == 8'hFF) && (fb != 23'd0);
  assign inf_a   = (ea == 8'hFF) && (fa == 23'd0);
  assign inf_b   = (eb == 8'hFF) && (fb == 23'd0);
  assign zero_a  = (ea == 8'h00);
  assign zero_b  = (eb == 8'h00);

  always_comb begin
    spec_hit   = 1'b1;
    spec_quot  = 32'd0;
    spec_flags = 4'b0000;
    if (nan_a || nan_b || (zero_a && zero_b) || (inf_a && inf_b)) begin
      spec_quot  = NAN_VALUE;
      spec_flags = 4'b1000;
    end else if (zero_b && !inf_a) begin
      spec_quot  = {sign_in, 8'hFF, 23'd0};
      spec_flags = 4'b0100;
    end else if (inf_a) begin
      spec_quot  = {sign_in, 8'hFF, 23'd0};
    end else if (inf_b || zero_a) begin
      spec_quot  = {sign_in, 31'd0};
    end else begin
      spec_hit   = 1'b0;
    end
  end

  logic        ge;
  logic [24:0] rem_sub, rem_next;

  assign ge       = rem >= {1'b0, div_b};
  assign rem_sub  = ge ? rem - {1'b0, div_b} : rem;
  assign rem_next = rem_sub << 1;

  logic        [23:0] mant_raw;
  logic               guard, sticky, round_up;
  logic        [24:0] mant_sum;
  logic        [22:0] frac_fin;
  logic signed [9:0]  exp_n, exp_fin;
  logic        [31:0] rnd_quot;
  logic        [3:0]  rnd_flags;

  always_comb begin
    if (quo[25]) begin
      mant_raw = quo[25:2];
      guard    = quo[1];
      sticky   = quo[0] | (rem != 25'd0);
      exp_n    = exp_q;
    end else begin
      mant_raw = quo[24:1];
      guard    = quo[0];
      sticky   = (rem != 25'd0);
      exp_n    = exp_q - 10'sd1;
    end
    round_up = guard & (sticky | mant_raw[0]);
    mant_sum = {1'b0, mant_raw} + {24'd0, round_up};
    // carry out of rounding means the significand became exactly 2.0
    if (mant_sum[24]) begin
      frac_fin = 23'd0;
      exp_fin  = exp_n + 10'sd1;
    end else begin
      frac_fin = mant_sum[22:0];
      exp_fin  = exp_n;
    end
    if (exp_fin >= 10'sd255) begin
      rnd_quot  = {sign_q, 8'hFF, 23'd0};
      rnd_flags = 4'b0010;
    end else if (exp_fin <= 10'sd0) begin
      rnd_quot  = {sign_q, 31'd0};
      rnd_flags = 4'b0001;
    end else begin
      rnd_quot  = {sign_q, exp_fin[7:0], frac_fin};
      rnd_flags = 4'b0000;
    end
  end

  assign o_ready = (state == IDLE);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      o_valid <= 1'b0;
      o_quot  <= 32'd0;
      o_flags <= 4'd0;
      div_b   <= 24'd0;
      rem     <= 25'd0;
      quo     <= 26'd0;
      cnt     <= 5'd0;
      exp_q   <= 10'sd0;
      sign_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            sign_q <= sign_in;
            exp_q  <= $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;
            rem    <= {2'b01, fa};
            div_b  <= {1'b1, fb};
            quo    <= 26'd0;
            cnt    <= 5'd0;
            if (spec_hit) begin
              o_quot  <= spec_quot;
              o_flags <= spec_flags;
              state   <= OUT;
            end else begin
              state   <= DIV;
            end
          end
        end
        DIV: begin
          rem <= rem_next;
          quo <= {quo[24:0], ge};
          cnt <= cnt + 5'd1;
          if (cnt == 5'd25) state <= RND;
        end
        RND: begin
          o_quot  <= rnd_quot;
          o_flags <= rnd_flags;
          state   <= OUT;
        end
        OUT: begin
          // o_valid follows the result register by one cycle
          if (!o_valid) begin
            o_valid <= 1'b1;
          end else if (i_ready) begin
            o_valid <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp32_divider.sv
// Directed self-checking bench for fp32_divider: arithmetic, specials, range,
// latency, backpressure and reset during division.
module tb_fp32_divider;
  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [31:0] i_dividend = 32'd0;
  logic [31:0] i_divisor = 32'd0;
  logic        o_valid;
  logic        i_ready = 1'b0;
  logic [31:0] o_quot;
  logic [3:0]  o_flags;

  int checks = 0;
  int failures = 0;

  fp32_divider dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_dividend (i_dividend),
    .i_divisor  (i_divisor),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_quot     (o_quot),
    .o_flags    (o_flags)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // returns edges from acceptance to o_valid, or 999 if it never rises
  task automatic issue(input logic [31:0] a, input logic [31:0] b, output int lat);
    i_dividend = a;
    i_divisor  = b;
    i_valid    = 1'b1;
    tick();
    i_valid = 1'b0;
    lat = 0;
    while (!o_valid && lat < 100) begin
      tick();
      lat++;
    end
    if (!o_valid) lat = 999;
  endtask

  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eq, input logic [3:0] ef, input int elat);
    int lat;
    issue(a, b, lat);
    check({tag, " latency"}, lat, elat);
    check({tag, " quot"}, o_quot, eq);
    check({tag, " flags"}, {28'd0, o_flags}, {28'd0, ef});
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    check({tag, " ready after"}, {31'd0, o_ready}, 32'd1);
  endtask

  initial begin
    int lat;
    tick();
    tick();
    i_rst = 1'b0;
    check("reset valid", {31'd0, o_valid}, 32'd0);
    check("reset quot", o_quot, 32'd0);
    check("reset flags", {28'd0, o_flags}, 32'd0);
    check("reset ready", {31'd0, o_ready}, 32'd1);

    do_op("6/2",     32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 28);
    do_op("-6/2",    32'hC0C00000, 32'h40000000, 32'hC0400000, 4'b0000, 28);
    do_op("1/3",     32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000, 28);
    do_op("1/1",     32'h3F800000, 32'h3F800000, 32'h3F800000, 4'b0000, 28);
    do_op("1/0",     32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0100, 1);
    do_op("0/0",     32'h00000000, 32'h00000000, 32'h7FC00000, 4'b1000, 1);
    do_op("inf/inf", 32'h7F800000, 32'h7F800000, 32'h7FC00000, 4'b1000, 1);
    do_op("2/inf",   32'h40000000, 32'h7F800000, 32'h00000000, 4'b0000, 1);
    do_op("ovf",     32'h7F7FFFFF, 32'h3E800000, 32'h7F800000, 4'b0010, 28);
    do_op("unf",     32'h00800000, 32'h40000000, 32'h00000000, 4'b0001, 28);

    // backpressure: result must hold and new operands must be ignored
    issue(32'h40C00000, 32'h40000000, lat);
    check("bp latency", lat, 28);
    i_dividend = 32'h3F800000;
    i_divisor  = 32'h00000000;
    i_valid    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp quot", o_quot, 32'h40400000);
      check("bp valid", {31'd0, o_valid}, 32'd1);
      check("bp ready", {31'd0, o_ready}, 32'd0);
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    check("bp release ready", {31'd0, o_ready}, 32'd1);
    tick();
    check("bp nothing captured", {31'd0, o_valid}, 32'd0);
    check("bp idle ready", {31'd0, o_ready}, 32'd1);

    // reset while the divider is at counter 10
    i_dividend = 32'h40C00000;
    i_divisor  = 32'h40000000;
    i_valid    = 1'b1;
    tick();
    i_valid = 1'b0;
    repeat (10) tick();
    check("mid-div busy", {31'd0, o_ready}, 32'd0);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    check("rst valid", {31'd0, o_valid}, 32'd0);
    check("rst quot", o_quot, 32'd0);
    check("rst ready", {31'd0, o_ready}, 32'd1);
    do_op("6/2 after rst", 32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 28);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/fp32_divider.md
Name: fp32_divider

Overview:
- Sequential IEEE-754 single-precision divider: o_quot = i_dividend / i_divisor.
- It is the inverse-operation companion to the team's combinational FP32 multiplier and uses the same packed {sign, exp[7:0], frac[22:0]} format.
- Significands are divided by an iterative restoring divider, one quotient bit per cycle, followed by a round-to-nearest-even stage.
- Valid/ready handshakes on both input and output.

Parameters:
NAN_VALUE, 32'h7FC0_0000, canonical quiet NaN returned for invalid operations.

Ports:
i_clk  input  1  clock; all state changes on the rising edge.
i_rst  input  1  synchronous, active-high reset.
i_valid  input  1  operand pair valid.
o_ready  output  1  block can accept operands (high only in IDLE).
i_dividend  input  32  FP32 dividend.
i_divisor  input  32  FP32 divisor.
o_valid  output  1  result valid; held until accepted.
i_ready  input  1  downstream accepts the result.
o_quot  output  32  FP32 quotient.
o_flags  output  4  {invalid, div_by_zero, overflow, underflow}, valid with o_valid.

Behaviour:
- Reset: i_rst sampled high at an edge forces state IDLE, o_valid=0, o_quot=0, o_flags=0.
  - This applies in any state; an in-flight operation is discarded.
  - o_ready = (state==IDLE), so it is 1 in the cycle after reset.
- States:
  - IDLE: on i_valid&o_ready, capture operands and classify.
    - Special case -> OUT.
    - Otherwise -> DIV, with counter=0.
  - DIV: 26 cycles (counter 0..25), then -> RND.
  - RND: 1 cycle, then -> OUT.
  - OUT: o_valid=1; on i_ready -> IDLE.
- Latency: with acceptance at edge k, o_valid rises at edge k+1 for special cases and at edge k+28 for normal operands.
- Throughput: one operation in flight; o_ready=0 outside IDLE.
- Output stability: o_quot/o_flags stay stable while o_valid=1 and i_ready=0.
- Classification:
  - Exp=0 means zero; subnormal inputs are flushed to zero.
  - Exp=255 means inf if frac=0, NaN otherwise.
- Special cases, in priority order; sign = sA^sB except for NaN:
  - Either operand NaN, 0/0, or inf/inf -> NAN_VALUE, invalid=1.
  - Finite/0 -> signed inf (0x7F80_0000 | sign<<31), div_by_zero=1.
  - inf/finite -> signed inf, no flag.
  - finite/inf or 0/nonzero -> signed zero, no flag.
- Significand division: A={1,fracA}, B={1,fracB}, 25-bit remainder R initialised to A.
  - Each DIV cycle: if R>=B then q=1 and R=R-B, else q=0; then R=R<<1.
  - Q is shifted left, q entering at LSB; the 26 bits give Q = floor(A*2^25/B).
- Exponent: 10-bit signed, e = eA - eB + 127.
- Normalise (in RND):
  - If Q[25]: mant=Q[25:2], guard=Q[1], sticky=Q[0]|(R!=0).
  - Else: mant=Q[24:1], guard=Q[0], sticky=(R!=0), e=e-1.
- Rounding:
  - Round up if guard & (sticky | mant[0]).
  - If mant wraps to 2^24: mant=2^23, e=e+1.
- Range:
  - e>=255 -> signed inf, overflow=1.
  - e<=0 -> signed zero, underflow=1 (no subnormal output).
  - Otherwise o_quot = {sign, e[7:0], mant[22:0]}.
- Simultaneous events:
  - i_rst wins over every handshake.
  - i_valid in OUT is ignored (not captured) until back in IDLE.

Test Plan:
- 0x40C00000 / 0x40000000 (6/2) -> 0x40400000, flags 0, o_valid exactly 28 edges after acceptance; also 0xC0C00000 / 0x40000000 -> 0xC0400000.
- 0x3F800000 / 0x40400000 (1/3) -> 0x3EAAAAAB (RNE round-up), flags 0; 0x3F800000 / 0x3F800000 -> 0x3F800000.
- Specials: 0x3F800000/0x00000000 -> 0x7F800000 with div_by_zero; 0/0 -> 0x7FC00000 with invalid; 0x7F800000/0x7F800000 -> 0x7FC00000 with invalid; 0x40000000/0x7F800000 -> 0x00000000. All produce o_valid one edge after acceptance.
- Range: 0x7F7FFFFF/0x3E800000 -> 0x7F800000 with overflow; 0x00800000/0x40000000 -> 0x00000000 with underflow.
- Backpressure: hold i_ready=0 for 5 cycles after o_valid -> o_quot stable and o_ready=0; a new i_valid is not captured; i_ready=1 -> o_ready=1 next cycle.
- Reset mid-DIV (counter=10) -> next cycle o_valid=0, o_quot=0, o_ready=1; a following 6/2 yields 0x40400000.
